// File: rtl/morse_pkg.sv
// Shared definitions for the single-letter Morse transmitter: state encodings,
// letter codes, element kinds and per-phase unit counts.
package morse_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MARK  = 3'd1;
  localparam logic [2:0] SPACE = 3'd2;
  localparam logic [2:0] LGAP  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  typedef enum logic [2:0] {
    StIdle  = IDLE,
    StMark  = MARK,
    StSpace = SPACE,
    StLgap  = LGAP,
    StDone  = DONE
  } state_e;

  localparam logic [4:0]
    LTR_A = 5'd0,  LTR_B = 5'd1,  LTR_C = 5'd2,  LTR_D = 5'd3,  LTR_E = 5'd4,
    LTR_F = 5'd5,  LTR_G = 5'd6,  LTR_H = 5'd7,  LTR_I = 5'd8,  LTR_J = 5'd9,
    LTR_K = 5'd10, LTR_L = 5'd11, LTR_M = 5'd12, LTR_N = 5'd13, LTR_O = 5'd14,
    LTR_P = 5'd15, LTR_Q = 5'd16, LTR_R = 5'd17, LTR_S = 5'd18, LTR_T = 5'd19,
    LTR_U = 5'd20, LTR_V = 5'd21, LTR_W = 5'd22, LTR_X = 5'd23, LTR_Y = 5'd24,
    LTR_Z = 5'd25;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  localparam int unsigned UNITS_DOT   = 1;
  localparam int unsigned UNITS_DASH  = 3;
  localparam int unsigned UNITS_SPACE = 1;
  localparam int unsigned UNITS_LGAP  = 3;

endpackage

// File: rtl/morse_rom.sv
// Letter code to Morse element table. pat[len-1] is the first element sent;
// codes outside A-Z return len = 0.
module morse_rom
  import morse_pkg::*;
(
  input  logic [4:0] code,
  output logic [2:0] len,
  output logic [3:0] pat
);

  always_comb begin
    len = 3'd0;
    pat = 4'b0000;
    case (code)
      LTR_A: {len, pat} = {3'd2, 4'b0001};
      LTR_B: {len, pat} = {3'd4, 4'b1000};
      LTR_C: {len, pat} = {3'd4, 4'b1010};
      LTR_D: {len, pat} = {3'd3, 4'b0100};
      LTR_E: {len, pat} = {3'd1, 4'b0000};
      LTR_F: {len, pat} = {3'd4, 4'b0010};
      LTR_G: {len, pat} = {3'd3, 4'b0110};
      LTR_H: {len, pat} = {3'd4, 4'b0000};
      LTR_I: {len, pat} = {3'd2, 4'b0000};
      LTR_J: {len, pat} = {3'd4, 4'b0111};
      LTR_K: {len, pat} = {3'd3, 4'b0101};
      LTR_L: {len, pat} = {3'd4, 4'b0100};
      LTR_M: {len, pat} = {3'd2, 4'b0011};
      LTR_N: {len, pat} = {3'd2, 4'b0010};
      LTR_O: {len, pat} = {3'd3, 4'b0111};
      LTR_P: {len, pat} = {3'd4, 4'b0110};
      LTR_Q: {len, pat} = {3'd4, 4'b1101};
      LTR_R: {len, pat} = {3'd3, 4'b0010};
      LTR_S: {len, pat} = {3'd3, 4'b0000};
      LTR_T: {len, pat} = {3'd1, 4'b0001};
      LTR_U: {len, pat} = {3'd3, 4'b0001};
      LTR_V: {len, pat} = {3'd4, 4'b0001};
      LTR_W: {len, pat} = {3'd3, 4'b0011};
      LTR_X: {len, pat} = {3'd4, 4'b1001};
      LTR_Y: {len, pat} = {3'd4, 4'b1011};
      LTR_Z: {len, pat} = {3'd4, 4'b1100};
      default: {len, pat} = {3'd0, 4'b0000};
    endcase
  end

endmodule

// File: rtl/morse_letter_tx.sv
// Keys one latched letter out on tone as dots/dashes, then holds done until
// ack. Handshake mirrors the capture block so letters can be echoed.
module morse_letter_tx
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 6_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] c,
  input  logic       ack,
  output logic       tone,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CW = $clog2(3 * UNIT_CYCLES);

  localparam logic [CW-1:0] LastDot   = CW'(UNITS_DOT * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] LastDash  = CW'(UNITS_DASH * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] LastSpace = CW'(UNITS_SPACE * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] LastLgap  = CW'(UNITS_LGAP * UNIT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [2:0]      len_q, len_d;
  logic [3:0]      pat_q, pat_d;
  logic            err_q, err_d;

  logic [2:0]      rom_len;
  logic [3:0]      rom_pat;
  logic [1:0]      sel;
  logic            cur_dash;
  logic            last_elem;

  morse_rom u_rom (
    .code (c),
    .len  (rom_len),
    .pat  (rom_pat)
  );

  // Elements run from pat[len-1] down; mod-4 arithmetic keeps len = 4 correct.
  assign sel       = len_q[1:0] - 2'd1 - idx_q;
  assign cur_dash  = (pat_q[sel] == DASH);
  assign last_elem = ({1'b0, idx_q} == (len_q - 3'd1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    len_d   = len_q;
    pat_d   = pat_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) begin
          len_d   = rom_len;
          pat_d   = rom_pat;
          idx_d   = '0;
          err_d   = (rom_len == 3'd0);
          state_d = (rom_len == 3'd0) ? StDone : StMark;
        end
      end
      StMark: begin
        if (cnt_q == (cur_dash ? LastDash : LastDot)) begin
          cnt_d = '0;
          if (last_elem) begin
            state_d = StLgap;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = StSpace;
          end
        end
      end
      StSpace: begin
        if (cnt_q == LastSpace) begin
          cnt_d   = '0;
          state_d = StMark;
        end
      end
      StLgap: begin
        if (cnt_q == LastLgap) begin
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        cnt_d = '0;
        if (ack) state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      err_q   <= err_d;
    end
  end

  assign tone = (state_q == StMark);
  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign err  = done & err_q;

endmodule

// File: tb/tb_morse_letter_tx.sv
// Directed bench for morse_letter_tx with UNIT_CYCLES = 4: table of letters
// plus hand sequences for glitches, reset mid-mark and held done.
module tb_morse_letter_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [4:0] c = 5'd0;
  logic       ack = 1'b0;
  logic       tone, busy, done, err;

  int total = 0;
  int bad = 0;

  morse_letter_tx #(.UNIT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .c     (c),
    .ack   (ack),
    .tone  (tone),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] code;
    int         len;
    logic [3:0] pat;
    bit         err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sends one letter, checks every cycle of the waveform, done/err, then acks.
  task automatic send_chk(input logic [4:0] code, input int len, input logic [3:0] pat,
                          input bit exp_err, input bit glitch, input bit hold);
    bit exp_q[$];
    exp_q.delete();
    if (!exp_err) begin
      for (int i = len - 1; i >= 0; i--) begin
        repeat (pat[i] ? 12 : 4) exp_q.push_back(1'b1);
        repeat ((i > 0) ? 4 : 12) exp_q.push_back(1'b0);
      end
    end
    c = code;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      chk($sformatf("tone c%0d k%0d", code, k), {31'd0, tone}, {31'd0, exp_q[k]});
      chk($sformatf("busy c%0d k%0d", code, k), {31'd0, busy}, 32'd1);
      chk($sformatf("done_early c%0d k%0d", code, k), {31'd0, done}, 32'd0);
      if (glitch && k == 2) begin
        start = 1'b1;
        c = 5'd27;
      end
      if (glitch && k == 6) start = 1'b0;
    end
    @(negedge clk);
    chk($sformatf("done c%0d", code), {31'd0, done}, 32'd1);
    chk($sformatf("err c%0d", code), {31'd0, err}, {31'd0, exp_err});
    chk($sformatf("tone_done c%0d", code), {31'd0, tone}, 32'd0);
    if (hold) begin
      for (int h = 0; h < 10; h++) begin
        @(negedge clk);
        chk($sformatf("hold_done h%0d", h), {31'd0, done}, 32'd1);
      end
      start = 1'b1;
      c = 5'd4;
    end
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk($sformatf("ack_done c%0d", code), {31'd0, done}, 32'd0);
    chk($sformatf("ack_busy c%0d", code), {31'd0, busy}, 32'd0);
    chk($sformatf("ack_err c%0d", code), {31'd0, err}, 32'd0);
    if (hold) begin
      for (int h = 0; h < 3; h++) begin
        @(negedge clk);
        chk($sformatf("post_hold_busy h%0d", h), {31'd0, busy}, 32'd0);
        chk($sformatf("post_hold_tone h%0d", h), {31'd0, tone}, 32'd0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{code: 5'd4,  len: 1, pat: 4'b0000, err: 1'b0};  // E .
    vecs[1] = '{code: 5'd0,  len: 2, pat: 4'b0001, err: 1'b0};  // A .-
    vecs[2] = '{code: 5'd16, len: 4, pat: 4'b1101, err: 1'b0};  // Q --.-
    vecs[3] = '{code: 5'd19, len: 1, pat: 4'b0001, err: 1'b0};  // T -
    vecs[4] = '{code: 5'd27, len: 0, pat: 4'b0000, err: 1'b1};
    vecs[5] = '{code: 5'd25, len: 4, pat: 4'b1100, err: 1'b0};  // Z --..
    vecs[6] = '{code: 5'd7,  len: 4, pat: 4'b0000, err: 1'b0};  // H ....
    vecs[7] = '{code: 5'd31, len: 0, pat: 4'b0000, err: 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tone", {31'd0, tone}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++)
      send_chk(vecs[v].code, vecs[v].len, vecs[v].pat, vecs[v].err, 1'b0, 1'b0);

    // D -.. with start re-pulsed and c changed to an invalid code mid-letter
    send_chk(5'd3, 3, 4'b0100, 1'b0, 1'b1, 1'b0);

    // Reset during the first mark of O
    c = 5'd14;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("pre_rst_tone k%0d", k), {31'd0, tone}, 32'd1);
    end
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_tone", {31'd0, tone}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_busy k%0d", k), {31'd0, busy}, 32'd0);
    end
    send_chk(5'd4, 1, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Done held without ack, then ack and start together
    send_chk(5'd0, 2, 4'b0001, 1'b0, 1'b0, 1'b1);
    send_chk(5'd13, 2, 4'b0010, 1'b0, 1'b0, 1'b0);  // N -.

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
